// File: rtl/strela_exec_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module : strela_exec_csr_pkg
// Purpose: Shared definitions for the STRELA execution control/status bank:
//          register offsets, CTRL/STATUS bit positions, the execution state
//          enum, the register-bus request/response types and a byte-strobe
//          merge helper.
// Rev    : 1.0  initial release
// ============================================================================
package strela_exec_csr_pkg;

  // Register offsets (byte addresses within the decoded window)
  localparam int unsigned CTRL_OFS    = 32'h00;
  localparam int unsigned STATUS_OFS  = 32'h04;
  localparam int unsigned CYCLES_OFS  = 32'h08;
  localparam int unsigned RSVD_OFS    = 32'h0C;
  localparam int unsigned CH_BASE_OFS = 32'h10;
  localparam int unsigned CH_STRIDE   = 8;

  // CTRL bit positions
  localparam int unsigned CTRL_START_BIT    = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 1;
  localparam int unsigned CTRL_CLR_DONE_BIT = 2;

  // STATUS bit positions
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } exec_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  // Replace each byte of old_v whose strobe is set with the matching byte of new_v
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // 16-bit variant for fields that live only in the low half-word
  function automatic logic [15:0] strb_merge16(input logic [15:0] old_v,
                                               input logic [15:0] new_v,
                                               input logic [1:0]  strb);
    logic [15:0] res;
    res = old_v;
    for (int b = 0; b < 2; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/strela_exec_csr_if.sv
`default_nettype none
// ============================================================================
// Module : strela_exec_csr_if
// Purpose: Register-bus connection between the core and the execution CSR
//          bank.
// Ports  : req - request from the bus master (addr/write/wdata/wstrb/valid)
//          rsp - response from the bank (rdata/error/ready)
// Rev    : 1.0  initial release
// ============================================================================
interface strela_exec_csr_if;
  import strela_exec_csr_pkg::*;

  reg_req_t req;
  reg_rsp_t rsp;

  modport master (output req, input  rsp);
  modport slave  (input  req, output rsp);
endinterface
`default_nettype wire

// File: rtl/strela_exec_csr.sv
`default_nettype none
// ============================================================================
// Module : strela_exec_csr
// Purpose: Control/status register bank for the STRELA CGRA. Holds per-channel
//          memory descriptors, runs the start/busy/done handshake with the
//          fabric, counts execution cycles and raises a maskable interrupt.
// Ports  : clk_i, rst_ni          - clock, async active-low reset
//          reg_bus (slave)        - register bus, zero-latency response
//          data_input_*_o         - input channel descriptors (addr/size/stride)
//          data_output_*_o        - output channel descriptors (addr/size)
//          done_i                 - fabric completion, only looked at in RUN
//          execute_o              - one-cycle start pulse
//          busy_o                 - high while running
//          irq_o                  - DONE & IRQ_EN level interrupt
// Rev    : 1.0  initial release
// ============================================================================
module strela_exec_csr
  import strela_exec_csr_pkg::*;
#(
  parameter int unsigned INPUT_NODES_NUM  = 4,
  parameter int unsigned OUTPUT_NODES_NUM = 4,
  parameter int unsigned ADDR_W           = 8
) (
  input  wire logic                               clk_i,
  input  wire logic                               rst_ni,
  strela_exec_csr_if.slave                        reg_bus,
  output logic [INPUT_NODES_NUM-1:0][31:0]        data_input_addr_o,
  output logic [INPUT_NODES_NUM-1:0][15:0]        data_input_size_o,
  output logic [INPUT_NODES_NUM-1:0][15:0]        data_input_stride_o,
  output logic [OUTPUT_NODES_NUM-1:0][31:0]       data_output_addr_o,
  output logic [OUTPUT_NODES_NUM-1:0][15:0]       data_output_size_o,
  input  wire logic                               done_i,
  output logic                                    execute_o,
  output logic                                    busy_o,
  output logic                                    irq_o
);

  localparam int unsigned IN       = INPUT_NODES_NUM;
  localparam int unsigned OUT      = OUTPUT_NODES_NUM;
  localparam int unsigned IN_BASE  = CH_BASE_OFS;
  localparam int unsigned OUT_BASE = CH_BASE_OFS + CH_STRIDE * IN;

  exec_state_e r_state;
  logic        r_execute;
  logic        r_done;
  logic        r_irq_en;
  logic [31:0] r_cycles;

  logic [31:0] w_ofs;
  logic        w_misalign;
  logic        w_busy;
  logic        w_acc;
  logic        w_ch_wr;
  logic        w_ctrl_sel;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_clr;
  logic [IN-1:0]        w_in_sel;
  logic [OUT-1:0]       w_out_sel;
  logic [IN-1:0][31:0]  w_in_rd;
  logic [OUT-1:0][31:0] w_out_rd;
  logic [31:0] w_ch_rdata;
  logic        w_unused;

  // Only the low ADDR_W address bits take part in decode
  assign w_ofs      = 32'(reg_bus.req.addr[ADDR_W-1:0]);
  assign w_misalign = |reg_bus.req.addr[1:0];
  assign w_busy     = (r_state == RUN);
  assign w_acc      = reg_bus.req.valid & reg_bus.req.write & ~w_misalign;
  // Descriptors are frozen while the fabric is running
  assign w_ch_wr    = w_acc & ~w_busy;

  // All CTRL bits live in byte 0, so byte-0 strobe gates every CTRL field
  assign w_ctrl_sel = (w_ofs == CTRL_OFS);
  assign w_ctrl_wr  = w_acc & w_ctrl_sel & reg_bus.req.wstrb[0];
  assign w_start    = w_ctrl_wr & reg_bus.req.wdata[CTRL_START_BIT];
  assign w_clr      = w_ctrl_wr & reg_bus.req.wdata[CTRL_CLR_DONE_BIT];

  assign w_unused = ^{reg_bus.req.addr, reg_bus.req.wdata};

  // --------------------------------------------------------------------------
  // Input channel descriptors
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < IN; gi++) begin : g_in
    localparam logic [31:0] LO_OFS = 32'(IN_BASE + CH_STRIDE * gi);
    logic [31:0] r_addr;
    logic [15:0] r_size;
    logic [15:0] r_stride;
    logic        w_lo_sel;
    logic        w_hi_sel;

    assign w_lo_sel = (w_ofs == LO_OFS);
    assign w_hi_sel = (w_ofs == LO_OFS + 32'd4);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_addr   <= '0;
        r_size   <= '0;
        r_stride <= '0;
      end else if (w_ch_wr) begin
        if (w_lo_sel) r_addr <= strb_merge(r_addr, reg_bus.req.wdata, reg_bus.req.wstrb);
        if (w_hi_sel) {r_stride, r_size} <= strb_merge({r_stride, r_size},
                                                       reg_bus.req.wdata, reg_bus.req.wstrb);
      end
    end

    assign w_in_sel[gi] = w_lo_sel | w_hi_sel;
    assign w_in_rd[gi]  = w_lo_sel ? r_addr :
                          w_hi_sel ? {r_stride, r_size} : 32'h0;
    assign data_input_addr_o[gi]   = r_addr;
    assign data_input_size_o[gi]   = r_size;
    assign data_input_stride_o[gi] = r_stride;
  end

  // --------------------------------------------------------------------------
  // Output channel descriptors (size only in the low half-word)
  // --------------------------------------------------------------------------
  for (genvar go = 0; go < OUT; go++) begin : g_out
    localparam logic [31:0] LO_OFS = 32'(OUT_BASE + CH_STRIDE * go);
    logic [31:0] r_addr;
    logic [15:0] r_size;
    logic        w_lo_sel;
    logic        w_hi_sel;

    assign w_lo_sel = (w_ofs == LO_OFS);
    assign w_hi_sel = (w_ofs == LO_OFS + 32'd4);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_addr <= '0;
        r_size <= '0;
      end else if (w_ch_wr) begin
        if (w_lo_sel) r_addr <= strb_merge(r_addr, reg_bus.req.wdata, reg_bus.req.wstrb);
        if (w_hi_sel) r_size <= strb_merge16(r_size, reg_bus.req.wdata[15:0],
                                             reg_bus.req.wstrb[1:0]);
      end
    end

    assign w_out_sel[go] = w_lo_sel | w_hi_sel;
    assign w_out_rd[go]  = w_lo_sel ? r_addr :
                           w_hi_sel ? {16'h0, r_size} : 32'h0;
    assign data_output_addr_o[go] = r_addr;
    assign data_output_size_o[go] = r_size;
  end

  always_comb begin
    w_ch_rdata = '0;
    for (int k = 0; k < IN; k++)  w_ch_rdata = w_ch_rdata | w_in_rd[k];
    for (int k = 0; k < OUT; k++) w_ch_rdata = w_ch_rdata | w_out_rd[k];
  end

  // --------------------------------------------------------------------------
  // Combinational response
  // --------------------------------------------------------------------------
  always_comb begin
    reg_bus.rsp.rdata = '0;
    reg_bus.rsp.error = 1'b0;
    reg_bus.rsp.ready = 1'b1;
    if (w_misalign) begin
      reg_bus.rsp.error = 1'b1;
    end else if (w_ctrl_sel) begin
      reg_bus.rsp.rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
      reg_bus.rsp.error = w_start & w_busy;
    end else if (w_ofs == STATUS_OFS) begin
      reg_bus.rsp.rdata[STATUS_BUSY_BIT] = w_busy;
      reg_bus.rsp.rdata[STATUS_DONE_BIT] = r_done;
    end else if (w_ofs == CYCLES_OFS) begin
      reg_bus.rsp.rdata = r_cycles;
    end else if (w_ofs == RSVD_OFS) begin
      reg_bus.rsp.rdata = '0;
    end else if ((|w_in_sel) || (|w_out_sel)) begin
      reg_bus.rsp.rdata = w_ch_rdata;
      reg_bus.rsp.error = w_acc & w_busy;
    end else begin
      reg_bus.rsp.error = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Execution FSM, cycle counter, DONE/IRQ_EN
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_execute <= 1'b0;
      r_cycles  <= '0;
      r_done    <= 1'b0;
      r_irq_en  <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= reg_bus.req.wdata[CTRL_IRQ_EN_BIT];
      // Clear first so a completion in the same cycle overrides it below
      if (w_clr) r_done <= 1'b0;
      r_execute <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= RUN;
            r_execute <= 1'b1;
            r_cycles  <= '0;
            r_done    <= 1'b0;
          end
        end
        RUN: begin
          if (done_i) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (r_cycles != 32'hFFFF_FFFF) begin
            r_cycles <= r_cycles + 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign execute_o = r_execute;
  assign busy_o    = w_busy;
  assign irq_o     = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_strela_exec_csr.sv
`default_nettype none
// ============================================================================
// Module : tb_strela_exec_csr
// Purpose: Self-checking bench for strela_exec_csr (IN=2, OUT=3). Bus
//          responses are queued at issue time and checked by an independent
//          monitor; descriptor and handshake outputs are compared every cycle
//          against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_strela_exec_csr;
  import strela_exec_csr_pkg::*;

  localparam int IN  = 2;
  localparam int OUT = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic done;
  logic execute, busy, irq;
  logic [IN-1:0][31:0]  in_addr;
  logic [IN-1:0][15:0]  in_size, in_stride;
  logic [OUT-1:0][31:0] out_addr;
  logic [OUT-1:0][15:0] out_size;

  strela_exec_csr_if bus ();

  strela_exec_csr #(
    .INPUT_NODES_NUM (IN),
    .OUTPUT_NODES_NUM(OUT),
    .ADDR_W          (8)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .reg_bus            (bus),
    .data_input_addr_o  (in_addr),
    .data_input_size_o  (in_size),
    .data_input_stride_o(in_stride),
    .data_output_addr_o (out_addr),
    .data_output_size_o (out_size),
    .done_i             (done),
    .execute_o          (execute),
    .busy_o             (busy),
    .irq_o              (irq)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  bit              m_busy, m_exec, m_done, m_irq_en;
  longint unsigned m_cycles;
  logic [31:0] m_in_addr  [IN];
  logic [15:0] m_in_size  [IN];
  logic [15:0] m_in_stride[IN];
  logic [31:0] m_out_addr [OUT];
  logic [15:0] m_out_size [OUT];

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    bit          chk;
    logic [31:0] addr;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_exec = 0; m_done = 0; m_irq_en = 0; m_cycles = 0;
    for (int k = 0; k < IN; k++) begin
      m_in_addr[k] = 0; m_in_size[k] = 0; m_in_stride[k] = 0;
    end
    for (int k = 0; k < OUT; k++) begin
      m_out_addr[k] = 0; m_out_size[k] = 0;
    end
  endtask

  // Expected response for the current request given the current model state
  function automatic void exp_rsp(input logic [31:0] addr, input bit wr,
                                  input logic [31:0] wd, input logic [3:0] st,
                                  output logic [31:0] d, output logic e);
    int a, k;
    a = int'(addr[7:0]);
    d = 0;
    e = 0;
    if (a % 4 != 0) e = 1;
    else if (a == 0) begin
      d = {30'b0, m_irq_en, 1'b0};
      e = wr && st[0] && wd[0] && m_busy;
    end else if (a == 4) d = {30'b0, m_done, m_busy};
    else if (a == 8) d = m_cycles[31:0];
    else if (a == 12) d = 0;
    else if (a >= 16 && a < 16 + 8 * IN) begin
      k = (a - 16) / 8;
      d = (a % 8 == 0) ? m_in_addr[k] : {m_in_stride[k], m_in_size[k]};
      e = wr && m_busy;
    end else if (a >= 16 + 8 * IN && a < 16 + 8 * (IN + OUT)) begin
      k = (a - 16 - 8 * IN) / 8;
      d = (a % 8 == 0) ? m_out_addr[k] : {16'h0, m_out_size[k]};
      e = wr && m_busy;
    end else e = 1;
  endfunction

  // Advance the model across one rising edge using the inputs held on the bus
  task automatic model_step();
    int a, k;
    bit acc, start, clr, set_done;
    logic [31:0] t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    a = int'(bus.req.addr[7:0]);
    acc = bus.req.valid && bus.req.write && (a % 4 == 0);
    start = acc && a == 0 && bus.req.wstrb[0] && bus.req.wdata[0];
    clr   = acc && a == 0 && bus.req.wstrb[0] && bus.req.wdata[2];
    set_done = 0;
    if (acc && a == 0 && bus.req.wstrb[0]) m_irq_en = bus.req.wdata[1];
    if (acc && !m_busy) begin
      if (a >= 16 && a < 16 + 8 * IN) begin
        k = (a - 16) / 8;
        if (a % 8 == 0) m_in_addr[k] = bmerge(m_in_addr[k], bus.req.wdata, bus.req.wstrb);
        else begin
          t = bmerge({m_in_stride[k], m_in_size[k]}, bus.req.wdata, bus.req.wstrb);
          m_in_stride[k] = t[31:16];
          m_in_size[k]   = t[15:0];
        end
      end else if (a >= 16 + 8 * IN && a < 16 + 8 * (IN + OUT)) begin
        k = (a - 16 - 8 * IN) / 8;
        if (a % 8 == 0) m_out_addr[k] = bmerge(m_out_addr[k], bus.req.wdata, bus.req.wstrb);
        else begin
          t = bmerge({16'h0, m_out_size[k]}, bus.req.wdata, bus.req.wstrb);
          m_out_size[k] = t[15:0];
        end
      end
    end
    m_exec = 0;
    if (m_busy) begin
      if (done) begin
        m_busy = 0;
        set_done = 1;
      end else if (m_cycles < 64'hFFFF_FFFF) m_cycles = m_cycles + 1;
    end else if (start) begin
      m_busy = 1;
      m_exec = 1;
      m_cycles = 0;
    end
    if (set_done) m_done = 1;
    else if (start || clr) m_done = 0;
  endtask

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input bit dn);
    bus.req.valid = v;
    bus.req.write = w;
    bus.req.addr  = a;
    bus.req.wdata = d;
    bus.req.wstrb = s;
    done = dn;
  endtask

  task automatic idle(input bit dn);
    drive(0, 0, 32'h0, 32'h0, 4'h0, dn);
    tick();
  endtask

  task automatic op_model(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit dn);
    exp_t e;
    drive(1, w, a, d, s, dn);
    exp_rsp(a, w, d, s, e.rdata, e.error);
    e.chk = 1;
    e.addr = a;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic op_const(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit dn, input logic [31:0] ed,
                          input logic ee, input bit chk);
    exp_t e;
    drive(1, w, a, d, s, dn);
    e.rdata = ed;
    e.error = ee;
    e.chk = chk;
    e.addr = a;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic ee);
    op_const(0, a, 32'h0, 4'h0, 0, ed, ee, 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic ee);
    op_const(1, a, d, 4'hF, 0, 32'h0, ee, 0);
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.req.valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_underflow: response at addr %h with nothing expected", bus.req.addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.rsp.error !== e.error || bus.rsp.ready !== 1'b1 ||
              (e.chk && bus.rsp.rdata !== e.rdata)) begin
            n_fail++;
            $display("FAIL rsp addr=%h: got rdata=%h err=%b rdy=%b, want rdata=%h err=%b (data checked=%0d)",
                     e.addr, bus.rsp.rdata, bus.rsp.error, bus.rsp.ready, e.rdata, e.error, e.chk);
          end
        end
      end
      n_tests++;
      if ({busy, execute, irq} !== {m_busy, m_exec, m_done & m_irq_en}) begin
        n_fail++;
        $display("FAIL handshake @%0t: got busy/exec/irq=%b%b%b, want %b%b%b", $time,
                 busy, execute, irq, m_busy, m_exec, m_done & m_irq_en);
      end
      for (int k = 0; k < IN; k++) begin
        n_tests++;
        if (in_addr[k] !== m_in_addr[k] || in_size[k] !== m_in_size[k] ||
            in_stride[k] !== m_in_stride[k]) begin
          n_fail++;
          $display("FAIL in_desc[%0d] @%0t: got %h/%h/%h, want %h/%h/%h", k, $time,
                   in_addr[k], in_size[k], in_stride[k], m_in_addr[k], m_in_size[k], m_in_stride[k]);
        end
      end
      for (int k = 0; k < OUT; k++) begin
        n_tests++;
        if (out_addr[k] !== m_out_addr[k] || out_size[k] !== m_out_size[k]) begin
          n_fail++;
          $display("FAIL out_desc[%0d] @%0t: got %h/%h, want %h/%h", k, $time,
                   out_addr[k], out_size[k], m_out_addr[k], m_out_size[k]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] r, lo;
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 4'h0, 0);
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset defaults over the whole map, misaligned and out-of-range
    for (int a = 0; a < 16 + 8 * (IN + OUT); a += 4) rd(32'(a), 32'h0, 1'b0);
    rd(32'h02, 32'h0, 1'b1);
    rd(32'h38, 32'h0, 1'b1);

    // Byte-strobe write to channel-0 {stride,size}
    op_const(1, 32'h14, 32'hAABB_CCDD, 4'b0101, 0, 32'h0, 1'b0, 0);
    rd(32'h14, 32'h00BB_00DD, 1'b0);

    // Start with IRQ enabled, 10 running cycles, then completion
    wr(32'h00, 32'h3, 1'b0);
    repeat (10) idle(0);
    idle(1);
    rd(32'h08, 32'd10, 1'b0);
    rd(32'h04, 32'h2, 1'b0);

    // Busy protection: descriptor write and re-START both rejected
    wr(32'h00, 32'h1, 1'b0);
    wr(32'h10, 32'h1234, 1'b1);
    wr(32'h00, 32'h1, 1'b1);
    rd(32'h10, 32'h0, 1'b0);
    rd(32'h08, 32'd3, 1'b0);

    // CLR_DONE in the completion cycle loses; a later one clears
    op_const(1, 32'h00, 32'h6, 4'hF, 1, 32'h0, 1'b0, 0);
    rd(32'h04, 32'h2, 1'b0);
    wr(32'h00, 32'h6, 1'b0);
    rd(32'h04, 32'h0, 1'b0);

    // Last output channel is writable, the word after it is not
    wr(32'h30, 32'hDEAD_BEEF, 1'b0);
    rd(32'h30, 32'hDEAD_BEEF, 1'b0);
    wr(32'h34, 32'hFFFF_1234, 1'b0);
    rd(32'h34, 32'h0000_1234, 1'b0);
    wr(32'h38, 32'h5555_5555, 1'b1);
    wr(32'h10, 32'hCAFE_0000, 1'b0);

    // Reset in the middle of a run
    wr(32'h00, 32'h3, 1'b0);
    repeat (3) idle(0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) idle(0);
    rst_n = 1'b1;
    rd(32'h30, 32'h0, 1'b0);
    rd(32'h10, 32'h0, 1'b0);
    rd(32'h08, 32'h0, 1'b0);
    rd(32'h04, 32'h0, 1'b0);
    rd(32'h00, 32'h0, 1'b0);

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        idle($urandom_range(0, 5) == 0);
      end else begin
        lo = 32'($urandom_range(0, 8'h4F));
        if ($urandom_range(0, 7) != 0) lo[1:0] = 2'b00;
        if ($urandom_range(0, 7) == 0) lo = 32'h0;
        r = $urandom();
        op_model($urandom_range(0, 1) == 1, {r[23:0], lo[7:0]}, $urandom(),
                 4'($urandom_range(0, 15)), $urandom_range(0, 5) == 0);
      end
    end

    repeat (2) idle(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
